// File: rtl/rgmii_rx_inband_status_if.sv
// Receive-side RGMII in-band status bundle: the SDR receive nibble stream in,
// the qualified link/speed/duplex status out.
interface rgmii_rx_inband_status_if;
  logic       rx_dv;
  logic       rx_er;
  logic [3:0] rxd;
  logic       speed_10;
  logic       speed_100;
  logic       speed_1000;
  logic       link_up;
  logic       full_duplex;
  logic       status_valid;
  logic       status_changed;

  // No valid/ready flow control: every clock carries one nibble. rx_dv=0 and
  // rx_er=0 together mark an inter-frame status sample; anything else is frame
  // traffic and is not acknowledged or stalled.
  modport master (
    output rx_dv, rx_er, rxd,
    input  speed_10, speed_100, speed_1000, link_up, full_duplex,
    input  status_valid, status_changed
  );

  modport slave (
    input  rx_dv, rx_er, rxd,
    output speed_10, speed_100, speed_1000, link_up, full_duplex,
    output status_valid, status_changed
  );
endinterface

// File: rtl/rgmii_rx_inband_status.sv
// Decodes RGMII in-band link/speed/duplex status from inter-frame nibbles,
// debounces it over STABLE_COUNT samples and applies a link-loss timeout.
module rgmii_rx_inband_status #(
  parameter int STABLE_COUNT = 8,
  parameter int LINK_TIMEOUT = 1 << 20
) (
  input logic                      clk,
  input logic                      reset_n,
  rgmii_rx_inband_status_if.slave  rx
);
  localparam int RW = $clog2(STABLE_COUNT + 1);
  // One extra count beyond LINK_TIMEOUT lets the counter park past the firing value.
  localparam int TW = $clog2(LINK_TIMEOUT + 2);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_COUNT);
  localparam logic [TW-1:0] TO_FIRE = TW'(LINK_TIMEOUT);
  localparam logic [TW-1:0] TO_SAT  = TW'(LINK_TIMEOUT + 1);

  // Status words are kept in rxd packing: {duplex, speed[1:0], link}.
  logic [3:0]    cand_q, cand_d;
  logic [RW-1:0] run_q, run_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]    out_q, out_d;
  logic          valid_q, valid_d;
  logic          chg_q, chg_d;
  logic          status_smp;
  logic          reserved;
  logic          fire;

  always_comb begin
    cand_d     = cand_q;
    run_d      = run_q;
    to_d       = to_q;
    out_d      = out_q;
    valid_d    = valid_q;
    chg_d      = 1'b0;
    status_smp = !rx.rx_dv && !rx.rx_er;
    reserved   = (rx.rxd[2:1] == 2'b11);
    fire       = (LINK_TIMEOUT != 0) && (to_q == TO_FIRE);

    if (status_smp) begin
      to_d = '0;
      if (reserved) begin
        run_d = '0;
      end else if (rx.rxd == cand_q) begin
        if (run_q != RUN_MAX) run_d = run_q + RW'(1);
      end else begin
        cand_d = rx.rxd;
        run_d  = RW'(1);
      end
    end else if (to_q != TO_SAT) begin
      to_d = to_q + TW'(1);
    end

    // Timeout wins over a qualification landing on the same edge.
    if (fire) begin
      run_d    = '0;
      out_d[0] = 1'b0;
      chg_d    = out_q[0];
    end else if (run_q == RUN_MAX) begin
      valid_d = 1'b1;
      if (cand_q != out_q) begin
        out_d = cand_q;
        chg_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cand_q  <= '0;
      run_q   <= '0;
      to_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      cand_q  <= cand_d;
      run_q   <= run_d;
      to_q    <= to_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
    end
  end

  // Reserved codes never reach out_q, so exactly one speed line is high.
  assign rx.speed_10       = (out_q[2:1] == 2'b00);
  assign rx.speed_100      = (out_q[2:1] == 2'b01);
  assign rx.speed_1000     = (out_q[2:1] == 2'b10);
  assign rx.link_up        = out_q[0];
  assign rx.full_duplex    = out_q[3];
  assign rx.status_valid   = valid_q;
  assign rx.status_changed = chg_q;
endmodule

// File: tb/tb_rgmii_rx_inband_status.sv
// Bench for rgmii_rx_inband_status: two instances (debounce 8 / no timeout and
// debounce 1 / timeout 16) share one stimulus stream and a behavioural model.
module tb_rgmii_rx_inband_status;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  rgmii_rx_inband_status_if if_a ();
  rgmii_rx_inband_status_if if_b ();

  rgmii_rx_inband_status #(.STABLE_COUNT(8), .LINK_TIMEOUT(0)) u_a (
    .clk(clk), .reset_n(reset_n), .rx(if_a)
  );
  rgmii_rx_inband_status #(.STABLE_COUNT(1), .LINK_TIMEOUT(16)) u_b (
    .clk(clk), .reset_n(reset_n), .rx(if_b)
  );

  // Behavioural model, index 0 = u_a, 1 = u_b.
  int         sc[2] = '{8, 1};
  int         lt[2] = '{0, 16};
  logic [3:0] hist[2][$];   // trailing run of identical valid status samples
  int         gap[2];       // consecutive non-status cycles
  logic       e_link[2];
  int         e_spd[2];     // Mb/s
  logic       e_dup[2];
  logic       e_valid[2];
  logic       e_chg[2];

  function automatic int mbps(input logic [1:0] c);
    case (c)
      2'b00:   return 10;
      2'b01:   return 100;
      2'b10:   return 1000;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset(input int m);
    hist[m].delete();
    gap[m]     = 0;
    e_link[m]  = 1'b0;
    e_spd[m]   = 10;
    e_dup[m]   = 1'b0;
    e_valid[m] = 1'b0;
    e_chg[m]   = 1'b0;
  endtask

  task automatic model_edge(input int m, input logic dv, input logic er, input logic [3:0] d);
    logic       status;
    logic       fire;
    logic [3:0] v;
    status   = !dv && !er;
    fire     = (lt[m] != 0) && (gap[m] == lt[m]);
    e_chg[m] = 1'b0;
    if (fire) begin
      e_chg[m]  = e_link[m];
      e_link[m] = 1'b0;
      hist[m].delete();
    end else if (hist[m].size() >= sc[m]) begin
      v = hist[m][0];
      e_valid[m] = 1'b1;
      if (v[0] != e_link[m] || mbps(v[2:1]) != e_spd[m] || v[3] != e_dup[m]) begin
        e_link[m] = v[0];
        e_spd[m]  = mbps(v[2:1]);
        e_dup[m]  = v[3];
        e_chg[m]  = 1'b1;
      end
    end
    gap[m] = status ? 0 : gap[m] + 1;
    if (status && !fire) begin
      if (mbps(d[2:1]) < 0) begin
        hist[m].delete();
      end else begin
        if (hist[m].size() > 0 && hist[m][0] != d) hist[m].delete();
        hist[m].push_back(d);
        if (hist[m].size() > sc[m]) void'(hist[m].pop_front());
      end
    end
  endtask

  function automatic logic [6:0] exp_vec(input int m);
    return {e_spd[m] == 10, e_spd[m] == 100, e_spd[m] == 1000,
            e_link[m], e_dup[m], e_valid[m], e_chg[m]};
  endfunction

  function automatic logic [6:0] obs_a();
    return {if_a.speed_10, if_a.speed_100, if_a.speed_1000, if_a.link_up,
            if_a.full_duplex, if_a.status_valid, if_a.status_changed};
  endfunction

  function automatic logic [6:0] obs_b();
    return {if_b.speed_10, if_b.speed_100, if_b.speed_1000, if_b.link_up,
            if_b.full_duplex, if_b.status_valid, if_b.status_changed};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic compare_all();
    chk("a_outputs", 32'(obs_a()), 32'(exp_vec(0)));
    chk("b_outputs", 32'(obs_b()), 32'(exp_vec(1)));
    chk("a_onehot", $countones({if_a.speed_10, if_a.speed_100, if_a.speed_1000}), 1);
    chk("b_onehot", $countones({if_b.speed_10, if_b.speed_100, if_b.speed_1000}), 1);
  endtask

  task automatic cycle(input logic dv, input logic er, input logic [3:0] d);
    if_a.rx_dv = dv; if_a.rx_er = er; if_a.rxd = d;
    if_b.rx_dv = dv; if_b.rx_er = er; if_b.rxd = d;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (!reset_n) model_reset(m);
      else model_edge(m, dv, er, d);
    end
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) cycle(1'b0, 1'b0, 4'h0);
    reset_n = 1'b1;
  endtask

  logic [3:0] pool[6] = '{4'h1, 4'h3, 4'h5, 4'hb, 4'h7, 4'h0};
  logic [3:0] rd;
  logic [1:0] fr;
  int         len;

  initial begin
    model_reset(0);
    model_reset(1);

    // Reset state
    do_reset(2);
    chk("reset_a", 32'(obs_a()), 32'h40);
    chk("reset_b", 32'(obs_b()), 32'h40);

    // Link/1000/half qualifies on the 9th edge
    repeat (8) cycle(1'b0, 1'b0, 4'b0101);
    chk("q1_link_early", 32'(if_a.link_up), 0);
    chk("q1_chg_early", 32'(if_a.status_changed), 0);
    cycle(1'b0, 1'b0, 4'b0101);
    chk("q1_link", 32'(if_a.link_up), 1);
    chk("q1_spd1000", 32'(if_a.speed_1000), 1);
    chk("q1_valid", 32'(if_a.status_valid), 1);
    chk("q1_chg", 32'(if_a.status_changed), 1);
    cycle(1'b0, 1'b0, 4'b0101);
    chk("q1_chg_once", 32'(if_a.status_changed), 0);

    // Interrupted run restarts the count
    repeat (5) cycle(1'b0, 1'b0, 4'b1011);
    cycle(1'b0, 1'b0, 4'b0101);
    repeat (8) cycle(1'b0, 1'b0, 4'b1011);
    chk("q2_hold_spd", 32'(if_a.speed_1000), 1);
    chk("q2_hold_dup", 32'(if_a.full_duplex), 0);
    cycle(1'b0, 1'b0, 4'b1011);
    chk("q2_spd100", 32'(if_a.speed_100), 1);
    chk("q2_dup", 32'(if_a.full_duplex), 1);
    chk("q2_chg", 32'(if_a.status_changed), 1);

    // Frame cycles stretch but do not break a run
    repeat (4) cycle(1'b0, 1'b0, 4'b0011);
    repeat (20) cycle(1'b1, 1'b0, 4'ha);
    repeat (4) cycle(1'b0, 1'b0, 4'b0011);
    chk("q3_hold_dup", 32'(if_a.full_duplex), 1);
    cycle(1'b0, 1'b0, 4'b0011);
    chk("q3_dup", 32'(if_a.full_duplex), 0);
    chk("q3_chg", 32'(if_a.status_changed), 1);
    chk("q3_spd100", 32'(if_a.speed_100), 1);

    // Reserved speed never qualifies
    do_reset(1);
    repeat (20) cycle(1'b0, 1'b0, 4'b0111);
    chk("rsv_valid_a", 32'(if_a.status_valid), 0);
    chk("rsv_valid_b", 32'(if_b.status_valid), 0);
    chk("rsv_spd10", 32'(if_a.speed_10), 1);
    chk("rsv_link", 32'(if_b.link_up), 0);

    // Timeout on the debounce-1 instance
    repeat (2) cycle(1'b0, 1'b0, 4'b0011);
    chk("to_link_up", 32'(if_b.link_up), 1);
    chk("to_up_chg", 32'(if_b.status_changed), 1);
    repeat (16) cycle(1'b1, 1'b0, 4'h5);
    chk("to_link_held", 32'(if_b.link_up), 1);
    cycle(1'b1, 1'b0, 4'h5);
    chk("to_link_down", 32'(if_b.link_up), 0);
    chk("to_chg", 32'(if_b.status_changed), 1);
    chk("to_spd_kept", 32'(if_b.speed_100), 1);
    cycle(1'b1, 1'b0, 4'h5);
    chk("to_chg_once", 32'(if_b.status_changed), 0);

    // Reset at 7 of 8 discards the run
    do_reset(1);
    repeat (7) cycle(1'b0, 1'b0, 4'b1001);
    do_reset(1);
    chk("rr_reset_a", 32'(obs_a()), 32'h40);
    repeat (8) cycle(1'b0, 1'b0, 4'b1001);
    chk("rr_link_early", 32'(if_a.link_up), 0);
    cycle(1'b0, 1'b0, 4'b1001);
    chk("rr_link", 32'(if_a.link_up), 1);
    chk("rr_dup", 32'(if_a.full_duplex), 1);
    chk("rr_spd10", 32'(if_a.speed_10), 1);
    chk("rr_chg", 32'(if_a.status_changed), 1);

    // Randomized runs, frame interleaving, long gaps and resets
    for (int blk = 0; blk < 200; blk++) begin
      rd  = pool[$urandom_range(0, 5)];
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 99) < 15) begin
          fr = 2'($urandom_range(1, 3));
          cycle(fr[1], fr[0], 4'($urandom_range(0, 15)));
        end else begin
          cycle(1'b0, 1'b0, rd);
        end
      end
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(10, 25)) begin
          fr = 2'($urandom_range(1, 3));
          cycle(fr[1], fr[0], 4'($urandom_range(0, 15)));
        end
      end
      if ($urandom_range(0, 49) == 0) do_reset(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
